// File: rtl/regfile_port_arbiter.sv
// regfile_port_arbiter
// Shares the two read ports and the single write port of a 32x16 register file
// among NUM_REQ requesters. Reads and writes each use their own round-robin pointer.
// A read response has one cycle of latency. It is returned on a shared bus, tagged
// one-hot with the requester that owns it, and is held until that requester accepts it.
// Optional feature macro: REGFILE_ARB_BYPASS_EN. When it is defined, a write granted
// in the same cycle as a read to the same index is forwarded into the read response.

module regfile_port_arbiter #(
   parameter int NUM_REQ = 2,
   parameter int DATA_W  = 16,
   parameter int IDX_W   = 5
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [NUM_REQ-1:0]        rd_req,
   input  logic [NUM_REQ*IDX_W-1:0]  rd_idx_a,
   input  logic [NUM_REQ*IDX_W-1:0]  rd_idx_b,
   output logic [NUM_REQ-1:0]        rd_gnt,
   output logic [NUM_REQ-1:0]        rd_rsp_valid,
   input  logic [NUM_REQ-1:0]        rd_rsp_ready,
   output logic [DATA_W-1:0]         rd_rsp_data_a,
   output logic [DATA_W-1:0]         rd_rsp_data_b,
   input  logic [NUM_REQ-1:0]        wr_req,
   input  logic [NUM_REQ*IDX_W-1:0]  wr_idx,
   input  logic [NUM_REQ*DATA_W-1:0] wr_data,
   output logic [NUM_REQ-1:0]        wr_gnt,
   output logic                      rf_r_en_a,
   output logic                      rf_r_en_b,
   output logic [IDX_W-1:0]          rf_r_idx_a,
   output logic [IDX_W-1:0]          rf_r_idx_b,
   input  logic [DATA_W-1:0]         rf_r_data_a,
   input  logic [DATA_W-1:0]         rf_r_data_b,
   output logic                      rf_w_en,
   output logic [IDX_W-1:0]          rf_w_idx,
   output logic [DATA_W-1:0]         rf_w_data
);

   localparam int PTR_W = (NUM_REQ > 2) ? 2 : 1;

   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr_nxt;
   logic [PTR_W-1:0] wr_ptr_nxt;
   logic             rd_stall;

   // Rotate the requests so that ptr lands at bit 0, keep the lowest set bit,
   // then rotate that bit back into place. The two halves of the double-width
   // word are ORed to handle the wrap past the top requester.
   function automatic logic [NUM_REQ-1:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                                  input logic [PTR_W-1:0]   ptr);
      logic [2*NUM_REQ-1:0] dbl;
      logic [2*NUM_REQ-1:0] placed;
      logic [NUM_REQ-1:0]   rot;
      logic [NUM_REQ-1:0]   first;
      dbl    = {req, req} >> ptr;
      rot    = dbl[NUM_REQ-1:0];
      first  = rot & (~rot + NUM_REQ'(1));
      placed = {{NUM_REQ{1'b0}}, first} << ptr;
      return placed[NUM_REQ-1:0] | placed[2*NUM_REQ-1:NUM_REQ];
   endfunction

   // A held response whose owner is not ready blocks new reads, so the register
   // file keeps its output and the response stays stable.
   assign rd_stall = |(rd_rsp_valid & ~rd_rsp_ready);

   // Grants are combinational and forced to zero while reset is asserted.
   always_comb begin
      rd_gnt = '0;
      wr_gnt = '0;
      if (reset) begin
         if (!rd_stall) begin
            rd_gnt = rr_pick(rd_req, rd_ptr);
         end
         wr_gnt = rr_pick(wr_req, wr_ptr);
      end
   end

   // Steer the granted requester onto the register file ports and work out where
   // each pointer moves next. Idle ports drive zeros.
   always_comb begin
      rf_r_idx_a = '0;
      rf_r_idx_b = '0;
      rf_w_idx   = '0;
      rf_w_data  = '0;
      rd_ptr_nxt = rd_ptr;
      wr_ptr_nxt = wr_ptr;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (rd_gnt[i]) begin
            rf_r_idx_a = rd_idx_a[i*IDX_W +: IDX_W];
            rf_r_idx_b = rd_idx_b[i*IDX_W +: IDX_W];
            rd_ptr_nxt = PTR_W'((i + 1) % NUM_REQ);
         end
         if (wr_gnt[i]) begin
            rf_w_idx   = wr_idx[i*IDX_W +: IDX_W];
            rf_w_data  = wr_data[i*DATA_W +: DATA_W];
            wr_ptr_nxt = PTR_W'((i + 1) % NUM_REQ);
         end
      end
   end

   assign rf_r_en_a = |rd_gnt;
   assign rf_r_en_b = |rd_gnt;
   assign rf_w_en   = |wr_gnt;

   // Pointers advance past each granted requester. A response is loaded in the
   // cycle after its grant. Whenever the bus is not stalled it is replaced by the
   // new grant, or it clears if there is no new grant.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rd_ptr       <= '0;
         wr_ptr       <= '0;
         rd_rsp_valid <= '0;
      end else begin
         if (|rd_gnt) begin
            rd_ptr <= rd_ptr_nxt;
         end
         if (|wr_gnt) begin
            wr_ptr <= wr_ptr_nxt;
         end
         if (!rd_stall) begin
            rd_rsp_valid <= rd_gnt;
         end
      end
   end

`ifdef REGFILE_ARB_BYPASS_EN
   logic              byp_a;
   logic              byp_b;
   logic [DATA_W-1:0] byp_data_a;
   logic [DATA_W-1:0] byp_data_b;
   logic              hit_a;
   logic              hit_b;

   assign hit_a = rf_r_en_a && rf_w_en && (rf_r_idx_a == rf_w_idx);
   assign hit_b = rf_r_en_b && rf_w_en && (rf_r_idx_b == rf_w_idx);

   // Capture write data that collides with a read granted in the same cycle. The
   // flags follow the response: they hold through a stall and are rewritten
   // whenever the bus moves on.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         byp_a      <= 1'b0;
         byp_b      <= 1'b0;
         byp_data_a <= '0;
         byp_data_b <= '0;
      end else if (!rd_stall) begin
         byp_a <= hit_a;
         byp_b <= hit_b;
         if (hit_a) begin
            byp_data_a <= rf_w_data;
         end
         if (hit_b) begin
            byp_data_b <= rf_w_data;
         end
      end
   end

   assign rd_rsp_data_a = byp_a ? byp_data_a : rf_r_data_a;
   assign rd_rsp_data_b = byp_b ? byp_data_b : rf_r_data_b;
`else
   assign rd_rsp_data_a = rf_r_data_a;
   assign rd_rsp_data_b = rf_r_data_b;
`endif

endmodule

// File: tb/tb_regfile_port_arbiter.sv
// tb_regfile_port_arbiter
// Directed, table-driven bench for regfile_port_arbiter with two requesters. It
// contains a behavioural 32x16 register file that has registered reads, plus a
// hand-written sequence that asserts reset while a response is pending.
// Expected bypass results follow the REGFILE_ARB_BYPASS_EN macro.

module tb_regfile_port_arbiter;

   localparam int NUM_REQ = 2;
   localparam int DATA_W  = 16;
   localparam int IDX_W   = 5;

`ifdef REGFILE_ARB_BYPASS_EN
   localparam logic [15:0] BYP_R7 = 16'h00AA;
`else
   localparam logic [15:0] BYP_R7 = 16'h0005;
`endif

   logic                      clk;
   logic                      reset;
   logic [NUM_REQ-1:0]        rd_req;
   logic [NUM_REQ*IDX_W-1:0]  rd_idx_a;
   logic [NUM_REQ*IDX_W-1:0]  rd_idx_b;
   logic [NUM_REQ-1:0]        rd_gnt;
   logic [NUM_REQ-1:0]        rd_rsp_valid;
   logic [NUM_REQ-1:0]        rd_rsp_ready;
   logic [DATA_W-1:0]         rd_rsp_data_a;
   logic [DATA_W-1:0]         rd_rsp_data_b;
   logic [NUM_REQ-1:0]        wr_req;
   logic [NUM_REQ*IDX_W-1:0]  wr_idx;
   logic [NUM_REQ*DATA_W-1:0] wr_data;
   logic [NUM_REQ-1:0]        wr_gnt;
   logic                      rf_r_en_a;
   logic                      rf_r_en_b;
   logic [IDX_W-1:0]          rf_r_idx_a;
   logic [IDX_W-1:0]          rf_r_idx_b;
   logic [DATA_W-1:0]         rf_r_data_a;
   logic [DATA_W-1:0]         rf_r_data_b;
   logic                      rf_w_en;
   logic [IDX_W-1:0]          rf_w_idx;
   logic [DATA_W-1:0]         rf_w_data;

   logic [DATA_W-1:0] rfMem [32];

   int nChecks;
   int nErrors;

   typedef struct {
      logic [1:0]  rdReq;
      logic [4:0]  ia0, ib0, ia1, ib1;
      logic [1:0]  rdy;
      logic [1:0]  wrReq;
      logic [4:0]  wi0;
      logic [15:0] wd0;
      logic [4:0]  wi1;
      logic [15:0] wd1;
      logic [1:0]  expRdGnt;
      logic [1:0]  expWrGnt;
      logic [1:0]  expValid;
      logic [15:0] expA;
      logic [15:0] expB;
   } vec_t;

   vec_t vecs[$];

   regfile_port_arbiter #(
      .NUM_REQ(NUM_REQ),
      .DATA_W (DATA_W),
      .IDX_W  (IDX_W)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .rd_req       (rd_req),
      .rd_idx_a     (rd_idx_a),
      .rd_idx_b     (rd_idx_b),
      .rd_gnt       (rd_gnt),
      .rd_rsp_valid (rd_rsp_valid),
      .rd_rsp_ready (rd_rsp_ready),
      .rd_rsp_data_a(rd_rsp_data_a),
      .rd_rsp_data_b(rd_rsp_data_b),
      .wr_req       (wr_req),
      .wr_idx       (wr_idx),
      .wr_data      (wr_data),
      .wr_gnt       (wr_gnt),
      .rf_r_en_a    (rf_r_en_a),
      .rf_r_en_b    (rf_r_en_b),
      .rf_r_idx_a   (rf_r_idx_a),
      .rf_r_idx_b   (rf_r_idx_b),
      .rf_r_data_a  (rf_r_data_a),
      .rf_r_data_b  (rf_r_data_b),
      .rf_w_en      (rf_w_en),
      .rf_w_idx     (rf_w_idx),
      .rf_w_data    (rf_w_data)
   );

   // Free-running clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Behavioural register file: the read returns the value from before any
   // write in the same cycle, and the outputs hold while read enable is low.
   initial begin
      for (int i = 0; i < 32; i++) rfMem[i] = '0;
      rf_r_data_a = '0;
      rf_r_data_b = '0;
   end

   always @(posedge clk) begin
      if (rf_w_en) rfMem[rf_w_idx] <= rf_w_data;
      if (rf_r_en_a) rf_r_data_a <= rfMem[rf_r_idx_a];
      if (rf_r_en_b) rf_r_data_b <= rfMem[rf_r_idx_b];
   end

   task automatic addVec(input logic [1:0] rr, input logic [4:0] ia0, ib0, ia1, ib1,
                         input logic [1:0] rdy, input logic [1:0] wr,
                         input logic [4:0] wi0, input logic [15:0] wd0,
                         input logic [4:0] wi1, input logic [15:0] wd1,
                         input logic [1:0] erg, ewg, ev,
                         input logic [15:0] ea, eb);
      vec_t v;
      v.rdReq = rr; v.ia0 = ia0; v.ib0 = ib0; v.ia1 = ia1; v.ib1 = ib1;
      v.rdy = rdy; v.wrReq = wr; v.wi0 = wi0; v.wd0 = wd0; v.wi1 = wi1; v.wd1 = wd1;
      v.expRdGnt = erg; v.expWrGnt = ewg; v.expValid = ev; v.expA = ea; v.expB = eb;
      vecs.push_back(v);
   endtask

   task automatic applyStimulus(input vec_t v);
      rd_req       = v.rdReq;
      rd_idx_a     = {v.ia1, v.ia0};
      rd_idx_b     = {v.ib1, v.ib0};
      rd_rsp_ready = v.rdy;
      wr_req       = v.wrReq;
      wr_idx       = {v.wi1, v.wi0};
      wr_data      = {v.wd1, v.wd0};
   endtask

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      nChecks++;
      if (actual !== expected) begin
         nErrors++;
         $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
      end
   endtask

   // Main stimulus: reset, the directed cycle table, then reset with a pending response
   initial begin
      nChecks = 0;
      nErrors = 0;
      reset   = 1'b0;
      applyStimulus('{default: '0});

      //     rdReq  ia0 ib0 ia1 ib1 rdy   wrReq  wi0 wd0       wi1 wd1       rdGnt  wrGnt  valid  dataA     dataB
      // write R3 through req0, then req1 reads it back on port A
      addVec(2'b00, 0, 0, 0, 0, 2'b11, 2'b01, 3, 16'h1234, 0, 16'h0000, 2'b00, 2'b01, 2'b00, 16'h0000, 16'h0000);
      addVec(2'b10, 0, 0, 3, 0, 2'b11, 2'b00, 0, 16'h0000, 0, 16'h0000, 2'b10, 2'b00, 2'b00, 16'h0000, 16'h0000);
      addVec(2'b00, 0, 0, 0, 0, 2'b11, 2'b00, 0, 16'h0000, 0, 16'h0000, 2'b00, 2'b00, 2'b10, 16'h1234, 16'h0000);
      // both requesters read back-to-back, grants alternate
      addVec(2'b11, 3, 0, 0, 3, 2'b11, 2'b00, 0, 16'h0000, 0, 16'h0000, 2'b01, 2'b00, 2'b00, 16'h0000, 16'h0000);
      addVec(2'b11, 3, 0, 0, 3, 2'b11, 2'b00, 0, 16'h0000, 0, 16'h0000, 2'b10, 2'b00, 2'b01, 16'h1234, 16'h0000);
      addVec(2'b11, 3, 0, 0, 3, 2'b11, 2'b00, 0, 16'h0000, 0, 16'h0000, 2'b01, 2'b00, 2'b10, 16'h0000, 16'h1234);
      addVec(2'b11, 3, 0, 0, 3, 2'b11, 2'b00, 0, 16'h0000, 0, 16'h0000, 2'b10, 2'b00, 2'b01, 16'h1234, 16'h0000);
      addVec(2'b00, 0, 0, 0, 0, 2'b11, 2'b00, 0, 16'h0000, 0, 16'h0000, 2'b00, 2'b00, 2'b10, 16'h0000, 16'h1234);
      // stall: req0 holds a BEEF response while req1 waits and R5 is overwritten
      addVec(2'b00, 0, 0, 0, 0, 2'b11, 2'b01, 5, 16'hBEEF, 0, 16'h0000, 2'b00, 2'b01, 2'b00, 16'h0000, 16'h0000);
      addVec(2'b01, 5, 3, 0, 0, 2'b00, 2'b00, 0, 16'h0000, 0, 16'h0000, 2'b01, 2'b00, 2'b00, 16'h0000, 16'h0000);
      addVec(2'b10, 5, 3, 5, 0, 2'b00, 2'b01, 5, 16'h0001, 0, 16'h0000, 2'b00, 2'b01, 2'b01, 16'hBEEF, 16'h1234);
      addVec(2'b10, 5, 3, 5, 0, 2'b00, 2'b00, 0, 16'h0000, 0, 16'h0000, 2'b00, 2'b00, 2'b01, 16'hBEEF, 16'h1234);
      addVec(2'b10, 5, 3, 5, 0, 2'b00, 2'b00, 0, 16'h0000, 0, 16'h0000, 2'b00, 2'b00, 2'b01, 16'hBEEF, 16'h1234);
      addVec(2'b10, 5, 3, 5, 0, 2'b01, 2'b00, 0, 16'h0000, 0, 16'h0000, 2'b10, 2'b00, 2'b01, 16'hBEEF, 16'h1234);
      addVec(2'b00, 0, 0, 0, 0, 2'b11, 2'b00, 0, 16'h0000, 0, 16'h0000, 2'b00, 2'b00, 2'b10, 16'h0001, 16'h0000);
      // same-cycle read and write of R7 on both ports
      addVec(2'b00, 0, 0, 0, 0, 2'b11, 2'b01, 7, 16'h0005, 0, 16'h0000, 2'b00, 2'b01, 2'b00, 16'h0000, 16'h0000);
      addVec(2'b01, 7, 7, 0, 0, 2'b11, 2'b01, 7, 16'h00AA, 0, 16'h0000, 2'b01, 2'b01, 2'b00, 16'h0000, 16'h0000);
      addVec(2'b00, 0, 0, 0, 0, 2'b11, 2'b00, 0, 16'h0000, 0, 16'h0000, 2'b00, 2'b00, 2'b01, BYP_R7,   BYP_R7);
      // both requesters write, then the four registers are read back
      addVec(2'b00, 0, 0, 0, 0, 2'b11, 2'b11, 8, 16'h1111, 9, 16'h2222, 2'b00, 2'b10, 2'b00, 16'h0000, 16'h0000);
      addVec(2'b00, 0, 0, 0, 0, 2'b11, 2'b11, 8, 16'h1111, 10, 16'h3333, 2'b00, 2'b01, 2'b00, 16'h0000, 16'h0000);
      addVec(2'b00, 0, 0, 0, 0, 2'b11, 2'b11, 11, 16'h4444, 10, 16'h3333, 2'b00, 2'b10, 2'b00, 16'h0000, 16'h0000);
      addVec(2'b00, 0, 0, 0, 0, 2'b11, 2'b11, 11, 16'h4444, 12, 16'h5555, 2'b00, 2'b01, 2'b00, 16'h0000, 16'h0000);
      addVec(2'b01, 8, 9, 0, 0, 2'b11, 2'b00, 0, 16'h0000, 0, 16'h0000, 2'b01, 2'b00, 2'b00, 16'h0000, 16'h0000);
      addVec(2'b01, 10, 11, 0, 0, 2'b11, 2'b00, 0, 16'h0000, 0, 16'h0000, 2'b01, 2'b00, 2'b01, 16'h1111, 16'h2222);
      addVec(2'b00, 0, 0, 0, 0, 2'b11, 2'b00, 0, 16'h0000, 0, 16'h0000, 2'b00, 2'b00, 2'b01, 16'h3333, 16'h4444);

      // reset state, with requests already asserted
      @(negedge clk);
      rd_req = 2'b11;
      wr_req = 2'b11;
      #1;
      checkOutput("reset rd_rsp_valid", 32'(rd_rsp_valid), 32'h0);
      checkOutput("reset rd_gnt", 32'(rd_gnt), 32'h0);
      checkOutput("reset wr_gnt", 32'(wr_gnt), 32'h0);
      @(negedge clk);
      applyStimulus('{default: '0});
      reset = 1'b1;

      for (int i = 0; i < vecs.size(); i++) begin
         @(negedge clk);
         applyStimulus(vecs[i]);
         #1;
         checkOutput($sformatf("c%0d rd_gnt", i), 32'(rd_gnt), 32'(vecs[i].expRdGnt));
         checkOutput($sformatf("c%0d wr_gnt", i), 32'(wr_gnt), 32'(vecs[i].expWrGnt));
         checkOutput($sformatf("c%0d rf_r_en", i), 32'({rf_r_en_a, rf_r_en_b}),
                     32'({2{|vecs[i].expRdGnt}}));
         checkOutput($sformatf("c%0d rf_w_en", i), 32'(rf_w_en), 32'(|vecs[i].expWrGnt));
         checkOutput($sformatf("c%0d rd_rsp_valid", i), 32'(rd_rsp_valid), 32'(vecs[i].expValid));
         if (vecs[i].expValid != 2'b00) begin
            checkOutput($sformatf("c%0d data_a", i), 32'(rd_rsp_data_a), 32'(vecs[i].expA));
            checkOutput($sformatf("c%0d data_b", i), 32'(rd_rsp_data_b), 32'(vecs[i].expB));
         end
      end

      // reset asserted while a response is pending
      @(negedge clk);
      applyStimulus('{default: '0});
      rd_req   = 2'b01;
      rd_idx_a = {5'd0, 5'd8};
      #1;
      checkOutput("pre-reset rd_gnt", 32'(rd_gnt), 32'h1);
      @(negedge clk);
      rd_rsp_ready = 2'b00;
      rd_req       = 2'b11;
      wr_req       = 2'b11;
      #1;
      checkOutput("pending rd_rsp_valid", 32'(rd_rsp_valid), 32'h1);
      reset = 1'b0;
      #1;
      checkOutput("async reset rd_rsp_valid", 32'(rd_rsp_valid), 32'h0);
      checkOutput("in reset rd_gnt", 32'(rd_gnt), 32'h0);
      checkOutput("in reset wr_gnt", 32'(wr_gnt), 32'h0);
      checkOutput("in reset rf_r_en_a", 32'(rf_r_en_a), 32'h0);
      @(negedge clk);
      reset        = 1'b1;
      rd_rsp_ready = 2'b11;
      #1;
      checkOutput("post-reset rd_gnt", 32'(rd_gnt), 32'h1);
      checkOutput("post-reset wr_gnt", 32'(wr_gnt), 32'h1);
      checkOutput("post-reset rd_rsp_valid", 32'(rd_rsp_valid), 32'h0);
      @(negedge clk);
      applyStimulus('{default: '0});
      #1;
      checkOutput("post-reset response", 32'(rd_rsp_valid), 32'h1);

      $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
      $finish;
   end

endmodule
